// File: rtl/bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : bus_sequencer
//  Purpose  : Shared system bus timing sequencer. Each CPU cycle of
//             CYCLE_LEN system clocks is split into four quarters:
//               Q0 video fetch, Q1 DMA window A, Q2-Q3 CPU access.
//             Q3 becomes DMA window B when the CPU is halted.
//             NUM_CH DMA requesters are served round-robin.
//  Ports    : clk_sys_i, reset_i        clock, async active-high reset
//             cpu_ready_i, bus_rw_ni    CPU run/halt and CPU direction
//             bus_data_i                data bus, captured on DMA reads
//             ch_*_i / ch_done_o        per-channel request and completion
//             rd_data_o                 last DMA read data
//             phi2_o, cpu_*_o           CPU clock and CPU bus strobes
//             video_*_o                 video slot and fetch strobes
//             dma_*_o                   granted channel's bus cycle
//  Revision : 1.0  initial release
// ============================================================================
module bus_sequencer #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8,
  parameter int CYCLE_LEN  = 16
) (
  input  logic                         clk_sys_i,
  input  logic                         reset_i,
  input  logic                         cpu_ready_i,
  input  logic                         bus_rw_ni,
  input  logic [DATA_WIDTH-1:0]        bus_data_i,
  input  logic [NUM_CH-1:0]            ch_pending_i,
  input  logic [NUM_CH-1:0]            ch_rw_ni,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i,
  output logic [NUM_CH-1:0]            ch_done_o,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  output logic                         phi2_o,
  output logic                         cpu_enable_o,
  output logic                         cpu_read_o,
  output logic                         cpu_write_o,
  output logic                         video_select_o,
  output logic                         video_ram_strobe_o,
  output logic                         video_rom_strobe_o,
  output logic                         dma_select_o,
  output logic [NUM_CH-1:0]            dma_grant_o,
  output logic [ADDR_WIDTH-1:0]        dma_addr_o,
  output logic [DATA_WIDTH-1:0]        dma_data_o,
  output logic                         dma_rw_no,
  output logic                         dma_read_o,
  output logic                         dma_write_o
);

  localparam int CNT_W = $clog2(CYCLE_LEN);
  localparam int Q     = CYCLE_LEN / 4;
  localparam int QW    = CNT_W - 2;
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_ARB_A   = CNT_W'(Q - 1);
  localparam logic [CNT_W-1:0] CNT_END_A   = CNT_W'(2 * Q - 1);
  localparam logic [CNT_W-1:0] CNT_ARB_B   = CNT_W'(3 * Q - 1);
  localparam logic [CNT_W-1:0] CNT_END_B   = CNT_W'(4 * Q - 1);
  localparam logic [CNT_W-1:0] CNT_VRAM    = CNT_W'(Q / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_VROM    = CNT_W'(Q - 1);
  localparam logic [CNT_W-1:0] CNT_WR_LO   = CNT_W'(2 * Q + 1);
  localparam logic [CNT_W-1:0] CNT_WR_HI   = CNT_W'(4 * Q - 2);
  localparam logic [QW-1:0]    OFF_LAST    = QW'(Q - 1);
  localparam logic [QW-1:0]    OFF_CAPTURE = QW'(Q - 2);
  localparam logic [SUM_W-1:0] SUM_NUM_CH  = SUM_W'(NUM_CH);

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]      cnt_q,        cnt_d;
  logic [PTR_W-1:0]      ptr_q,        ptr_d;
  logic                  b_open_q,     b_open_d;
  logic                  sel_q,        sel_d;
  logic [NUM_CH-1:0]     grant_q,      grant_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [DATA_WIDTH-1:0] data_q,       data_d;
  logic                  rw_q,         rw_d;
  logic                  dma_read_q,   dma_read_d;
  logic                  dma_write_q,  dma_write_d;
  logic [NUM_CH-1:0]     done_q,       done_d;
  logic [DATA_WIDTH-1:0] rd_data_q,    rd_data_d;
  logic                  phi2_q,       phi2_d;
  logic                  cpu_en_q,     cpu_en_d;
  logic                  cpu_rd_q,     cpu_rd_d;
  logic                  cpu_wr_q,     cpu_wr_d;
  logic                  vsel_q,       vsel_d;
  logic                  vram_q,       vram_d;
  logic                  vrom_q,       vrom_d;

  // --------------------------------------------------------------------------
  // Round-robin search from ptr_q
  // --------------------------------------------------------------------------
  logic                  arb_found;
  logic [PTR_W-1:0]      arb_idx;
  logic [SUM_W-1:0]      arb_sum;
  logic [SUM_W-1:0]      ptr_inc;
  logic [NUM_CH-1:0]     arb_grant;
  logic [ADDR_WIDTH-1:0] arb_addr;
  logic [DATA_WIDTH-1:0] arb_data;
  logic                  arb_rw;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_sum   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // (ptr + i) mod NUM_CH without a divider; ptr + i < 2*NUM_CH
      arb_sum = {1'b0, ptr_q} + SUM_W'(i);
      if (arb_sum >= SUM_NUM_CH) begin
        arb_sum = arb_sum - SUM_NUM_CH;
      end
      if (!arb_found && ch_pending_i[arb_sum[PTR_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_sum[PTR_W-1:0];
      end
    end
  end

  // Select the winning channel's request fields.
  always_comb begin
    arb_grant = '0;
    arb_addr  = '0;
    arb_data  = '0;
    arb_rw    = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (arb_idx == PTR_W'(k)) begin
        arb_grant[k] = 1'b1;
        arb_addr     = ch_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        arb_data     = ch_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        arb_rw       = ch_rw_ni[k];
      end
    end
  end

  assign ptr_inc = {1'b0, arb_idx} + SUM_W'(1);

  // --------------------------------------------------------------------------
  // Next-state logic. Every output register is loaded with the value that
  // belongs to cnt_d, so the outputs always match the counter they sit
  // beside and never glitch.
  // --------------------------------------------------------------------------
  logic          at_arb_a;
  logic          at_arb_b;
  logic          arb_now;
  logic          win_end;
  logic [1:0]    quarter_d;
  logic [QW-1:0] off_d;
  logic [QW-1:0] off_q;

  assign cnt_d     = cnt_q + 1'b1;   // power-of-two length wraps for free
  assign quarter_d = cnt_d[CNT_W-1 -: 2];
  assign off_d     = cnt_d[QW-1:0];
  assign off_q     = cnt_q[QW-1:0];
  assign at_arb_a  = (cnt_q == CNT_ARB_A);
  assign at_arb_b  = (cnt_q == CNT_ARB_B);
  assign arb_now   = at_arb_a || (at_arb_b && !cpu_ready_i);
  assign win_end   = (cnt_q == CNT_END_A) || (cnt_q == CNT_END_B);

  always_comb begin
    ptr_d     = ptr_q;
    b_open_d  = b_open_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rw_d      = rw_q;
    rd_data_d = rd_data_q;

    // Window B is decided once per cycle; a cpu_ready_i change elsewhere
    // waits for the next sample point.
    if (at_arb_b) begin
      b_open_d = !cpu_ready_i;
    end else if (cnt_q == CNT_END_B) begin
      b_open_d = 1'b0;
    end

    if (arb_now) begin
      sel_d   = arb_found;
      grant_d = arb_found ? arb_grant : '0;
      addr_d  = arb_found ? arb_addr  : '0;
      data_d  = arb_found ? arb_data  : '0;
      rw_d    = arb_found ? arb_rw    : 1'b1;
      if (arb_found) begin
        ptr_d = (ptr_inc >= SUM_NUM_CH) ? '0 : ptr_inc[PTR_W-1:0];
      end
    end else if (win_end) begin
      sel_d   = 1'b0;
      grant_d = '0;
      addr_d  = '0;
      data_d  = '0;
      rw_d    = 1'b1;
    end

    // Capture on the last clock of the read strobe so the RAM has had the
    // whole strobe to drive the bus.
    if (sel_q && rw_q && (off_q == OFF_CAPTURE)) begin
      rd_data_d = bus_data_i;
    end

    dma_read_d  = sel_d &&  rw_d && (off_d != '0) && (off_d != OFF_LAST);
    dma_write_d = sel_d && !rw_d && (off_d != '0) && (off_d != OFF_LAST);
    done_d      = (sel_d && (off_d == OFF_LAST)) ? grant_d : '0;

    phi2_d   = cnt_d[CNT_W-1];
    vsel_d   = (quarter_d == 2'd0);
    vram_d   = (cnt_d == CNT_VRAM);
    vrom_d   = (cnt_d == CNT_VROM);
    cpu_en_d = (quarter_d == 2'd2) || ((quarter_d == 2'd3) && !b_open_d);
    cpu_rd_d = cpu_en_d && bus_rw_ni;
    cpu_wr_d = cpu_en_d && !bus_rw_ni &&
               (cnt_d >= CNT_WR_LO) && (cnt_d <= CNT_WR_HI);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q       <= '0;
      ptr_q       <= '0;
      b_open_q    <= 1'b0;
      sel_q       <= 1'b0;
      grant_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rw_q        <= 1'b1;
      dma_read_q  <= 1'b0;
      dma_write_q <= 1'b0;
      done_q      <= '0;
      rd_data_q   <= '0;
      phi2_q      <= 1'b0;
      cpu_en_q    <= 1'b0;
      cpu_rd_q    <= 1'b0;
      cpu_wr_q    <= 1'b0;
      vsel_q      <= 1'b0;
      vram_q      <= 1'b0;
      vrom_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      b_open_q    <= b_open_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rw_q        <= rw_d;
      dma_read_q  <= dma_read_d;
      dma_write_q <= dma_write_d;
      done_q      <= done_d;
      rd_data_q   <= rd_data_d;
      phi2_q      <= phi2_d;
      cpu_en_q    <= cpu_en_d;
      cpu_rd_q    <= cpu_rd_d;
      cpu_wr_q    <= cpu_wr_d;
      vsel_q      <= vsel_d;
      vram_q      <= vram_d;
      vrom_q      <= vrom_d;
    end
  end

  assign ch_done_o          = done_q;
  assign rd_data_o          = rd_data_q;
  assign phi2_o             = phi2_q;
  assign cpu_enable_o       = cpu_en_q;
  assign cpu_read_o         = cpu_rd_q;
  assign cpu_write_o        = cpu_wr_q;
  assign video_select_o     = vsel_q;
  assign video_ram_strobe_o = vram_q;
  assign video_rom_strobe_o = vrom_q;
  assign dma_select_o       = sel_q;
  assign dma_grant_o        = grant_q;
  assign dma_addr_o         = addr_q;
  assign dma_data_o         = data_q;
  assign dma_rw_no          = rw_q;
  assign dma_read_o         = dma_read_q;
  assign dma_write_o        = dma_write_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_sequencer
//  Purpose  : Directed bench for bus_sequencer (NUM_CH=2, CYCLE_LEN=16).
//             Expected values are written out per counter position.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_sequencer;

  localparam int NCH = 2;
  localparam int AW  = 17;
  localparam int DW  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_ready;
  logic              bus_rw_n;
  logic [DW-1:0]     bus_data;
  logic [NCH-1:0]    ch_pending;
  logic [NCH-1:0]    ch_rw_n;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_done;
  logic [DW-1:0]     rd_data;
  logic              phi2, cpu_en, cpu_rd, cpu_wr;
  logic              vsel, vram, vrom;
  logic              dsel;
  logic [NCH-1:0]    grant;
  logic [AW-1:0]     daddr;
  logic [DW-1:0]     ddata;
  logic              drw_n, drd, dwr;

  bus_sequencer #(
    .NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CYCLE_LEN(16)
  ) u_dut (
    .clk_sys_i          (clk),
    .reset_i            (rst),
    .cpu_ready_i        (cpu_ready),
    .bus_rw_ni          (bus_rw_n),
    .bus_data_i         (bus_data),
    .ch_pending_i       (ch_pending),
    .ch_rw_ni           (ch_rw_n),
    .ch_addr_i          (ch_addr),
    .ch_data_i          (ch_data),
    .ch_done_o          (ch_done),
    .rd_data_o          (rd_data),
    .phi2_o             (phi2),
    .cpu_enable_o       (cpu_en),
    .cpu_read_o         (cpu_rd),
    .cpu_write_o        (cpu_wr),
    .video_select_o     (vsel),
    .video_ram_strobe_o (vram),
    .video_rom_strobe_o (vrom),
    .dma_select_o       (dsel),
    .dma_grant_o        (grant),
    .dma_addr_o         (daddr),
    .dma_data_o         (ddata),
    .dma_rw_no          (drw_n),
    .dma_read_o         (drd),
    .dma_write_o        (dwr)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int tb_cnt = 0;   // counter position the bench expects the DUT to be at

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s cnt=%0d got=%h want=%h", tag, tb_cnt, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    tb_cnt = (tb_cnt + 1) % 16;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tb_cnt = 0;
  endtask

  initial begin
    rst        = 1'b1;
    cpu_ready  = 1'b1;
    bus_rw_n   = 1'b1;
    bus_data   = 8'h00;
    ch_pending = '0;
    ch_rw_n    = '1;
    ch_addr    = '0;
    ch_data    = '0;

    // ---------------- reset values ----------------
    @(posedge clk);
    #1;
    chk("rst_phi2",  32'(phi2),    32'd0);
    chk("rst_vsel",  32'(vsel),    32'd0);
    chk("rst_cpuen", 32'(cpu_en),  32'd0);
    chk("rst_dsel",  32'(dsel),    32'd0);
    chk("rst_rw_n",  32'(drw_n),   32'd1);
    chk("rst_done",  32'(ch_done), 32'd0);
    chk("rst_rdata", 32'(rd_data), 32'd0);
    rst    = 1'b0;
    tb_cnt = 0;

    // ---------------- 1: free run, no requests ----------------
    for (int s = 0; s < 32; s++) begin
      step();
      chk("t1_phi2",  32'(phi2),      32'(tb_cnt >= 8));
      chk("t1_vram",  32'(vram),      32'(tb_cnt == 1));
      chk("t1_vrom",  32'(vrom),      32'(tb_cnt == 3));
      chk("t1_vsel",  32'(vsel),      32'(tb_cnt < 4));
      chk("t1_cpuen", 32'(cpu_en),    32'(tb_cnt >= 8));
      chk("t1_cpurd", 32'(cpu_rd),    32'(tb_cnt >= 8));
      chk("t1_dsel",  32'(dsel),      32'd0);
      chk("t1_dstb",  32'(drd | dwr), 32'd0);
      chk("t1_grant", 32'(grant),     32'd0);
    end

    // ---------------- 2: channel 0 read of 0x08000 ----------------
    ch_addr[0 +: AW] = 17'h08000;
    ch_rw_n[0]       = 1'b1;
    bus_data         = 8'hA5;
    ch_pending       = 2'b01;
    for (int s = 0; s < 16; s++) begin
      step();
      chk("t2_dsel",  32'(dsel),    32'(tb_cnt >= 4 && tb_cnt <= 7));
      chk("t2_grant", 32'(grant),   (tb_cnt >= 4 && tb_cnt <= 7) ? 32'd1 : 32'd0);
      chk("t2_addr",  32'(daddr),   (tb_cnt >= 4 && tb_cnt <= 7) ? 32'h08000 : 32'd0);
      chk("t2_rw_n",  32'(drw_n),   32'd1);
      chk("t2_read",  32'(drd),     32'(tb_cnt == 5 || tb_cnt == 6));
      chk("t2_write", 32'(dwr),     32'd0);
      chk("t2_done",  32'(ch_done), (tb_cnt == 7) ? 32'd1 : 32'd0);
      if (tb_cnt == 7) begin
        chk("t2_rdata", 32'(rd_data), 32'hA5);
        ch_pending = 2'b00;
      end
    end

    // ---------------- 3: channel 1 write of 0x3C to 0x1E812 ----------------
    bus_data          = 8'h5A;
    ch_addr[AW +: AW] = 17'h1E812;
    ch_data[DW +: DW] = 8'h3C;
    ch_rw_n[1]        = 1'b0;
    ch_pending        = 2'b10;
    bus_rw_n          = 1'b0;
    for (int s = 0; s < 16; s++) begin
      step();
      chk("t3_dsel",  32'(dsel),    32'(tb_cnt >= 4 && tb_cnt <= 7));
      chk("t3_grant", 32'(grant),   (tb_cnt >= 4 && tb_cnt <= 7) ? 32'd2 : 32'd0);
      chk("t3_addr",  32'(daddr),   (tb_cnt >= 4 && tb_cnt <= 7) ? 32'h1E812 : 32'd0);
      chk("t3_data",  32'(ddata),   (tb_cnt >= 4 && tb_cnt <= 7) ? 32'h3C : 32'd0);
      chk("t3_rw_n",  32'(drw_n),   32'(!(tb_cnt >= 4 && tb_cnt <= 7)));
      chk("t3_write", 32'(dwr),     32'(tb_cnt == 5 || tb_cnt == 6));
      chk("t3_read",  32'(drd),     32'd0);
      chk("t3_done",  32'(ch_done), (tb_cnt == 7) ? 32'd2 : 32'd0);
      chk("t3_rdhold",32'(rd_data), 32'hA5);
      chk("t3_cpuwr", 32'(cpu_wr),  32'(tb_cnt >= 9 && tb_cnt <= 14));
      chk("t3_cpurd", 32'(cpu_rd),  32'd0);
      if (tb_cnt == 7) ch_pending = 2'b00;
    end
    bus_rw_n = 1'b1;
    ch_rw_n  = 2'b11;

    // ---------------- 4: both pending, CPU running ----------------
    do_reset();
    ch_pending = 2'b11;
    for (int cyc = 0; cyc < 4; cyc++) begin
      for (int j = 0; j < 16; j++) begin
        step();
        if (tb_cnt == 5)
          chk("t4_grant", 32'(grant), (cyc % 2 == 0) ? 32'd1 : 32'd2);
        if (tb_cnt == 13)
          chk("t4_noB", 32'(dsel), 32'd0);
      end
    end

    // ---------------- 5: CPU halted, both pending ----------------
    do_reset();
    cpu_ready = 1'b0;
    for (int s = 0; s < 16; s++) begin
      step();
      chk("t5_grant", 32'(grant),
          (tb_cnt >= 4 && tb_cnt <= 7) ? 32'd1 :
          (tb_cnt >= 12 || tb_cnt == 0) && tb_cnt != 0 ? 32'd2 : 32'd0);
      chk("t5_cpuen", 32'(cpu_en), 32'(tb_cnt >= 8 && tb_cnt <= 11));
      chk("t5_done",  32'(ch_done),
          (tb_cnt == 7) ? 32'd1 : (tb_cnt == 15) ? 32'd2 : 32'd0);
    end
    cpu_ready  = 1'b1;
    ch_pending = 2'b00;

    // ---------------- 6: reset in the middle of a read ----------------
    do_reset();
    ch_pending = 2'b01;
    for (int s = 0; s < 5; s++) step();
    chk("t6_pre_read", 32'(drd), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_dsel",  32'(dsel),    32'd0);
    chk("t6_rst_grant", 32'(grant),   32'd0);
    chk("t6_rst_read",  32'(drd),     32'd0);
    chk("t6_rst_addr",  32'(daddr),   32'd0);
    chk("t6_rst_done",  32'(ch_done), 32'd0);
    @(posedge clk);
    #1;
    chk("t6_rst_done2", 32'(ch_done), 32'd0);
    rst    = 1'b0;
    tb_cnt = 0;
    for (int s = 0; s < 16; s++) begin
      step();
      chk("t6_grant", 32'(grant),   (tb_cnt >= 4 && tb_cnt <= 7) ? 32'd1 : 32'd0);
      chk("t6_done",  32'(ch_done), (tb_cnt == 7) ? 32'd1 : 32'd0);
      if (tb_cnt == 7) ch_pending = 2'b00;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_sequencer.md
# bus_sequencer

Multi-channel bus timing sequencer that divides each 1 MHz CPU cycle into fixed slots for video fetch, DMA and CPU access on the shared system bus. It generalises the single-requester CPU/RPi/video timing to `NUM_CH` DMA requesters, such as the SPI bridge and future masters, arbitrated round-robin. When the CPU is halted, it grants a second DMA slot per cycle. The top level uses its strobes to drive the RAM chip-enable, output-enable and write-enable lines and the address/data muxes.

## Interface
- `NUM_CH`, 2: number of DMA requester channels (1..8).
- `ADDR_WIDTH`, 17: system address width.
- `DATA_WIDTH`, 8: system data width.
- `CYCLE_LEN`, 16: `clk_sys_i` clocks per CPU cycle; power of 2, at least 16. Q = `CYCLE_LEN`/4.

Ports:
- `clk_sys_i`  in  1  16 MHz system clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `cpu_ready_i`  in  1  1 = CPU runs, 0 = CPU halted (its bus time is given to DMA).
- `bus_rw_ni`  in  1  CPU R/W (1 = read).
- `bus_data_i`  in  DATA_WIDTH  system data bus, sampled on DMA reads.
- `ch_pending_i`  in  NUM_CH  per-channel request (level).
- `ch_rw_ni`  in  NUM_CH  per-channel direction (1 = read).
- `ch_addr_i`  in  NUM_CH*ADDR_WIDTH  flattened addresses; channel k at `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `ch_data_i`  in  NUM_CH*DATA_WIDTH  flattened write data.
- `ch_done_o`  out  NUM_CH  one-clock completion pulse per channel.
- `rd_data_o`  out  DATA_WIDTH  last DMA read data, held until the next read completes.
- `phi2_o`  out  1  CPU clock.
- `cpu_enable_o`, `cpu_read_o`, `cpu_write_o`  out  1  CPU owns the bus / CPU read / CPU write.
- `video_select_o`, `video_ram_strobe_o`, `video_rom_strobe_o`  out  1  video slot and fetch strobes.
- `dma_select_o`  out  1  a DMA channel owns the bus.
- `dma_grant_o`  out  NUM_CH  one-hot granted channel.
- `dma_addr_o`  out  ADDR_WIDTH  granted channel's address.
- `dma_data_o`  out  DATA_WIDTH  granted channel's write data.
- `dma_rw_no`  out  1  granted channel's direction.
- `dma_read_o`, `dma_write_o`  out  1  RAM OE / WE strobes for DMA.

## Operation
- Free-running counter `cnt`, 0..`CYCLE_LEN`-1, wraps to 0.
- All outputs are registered and reflect the current `cnt` value with no glitches.
- `phi2_o` = 1 for `cnt` ≥ 2Q (50% duty cycle).

Video slot, quarter 0 (`cnt` 0..Q-1):
- `video_select_o` = 1 for the whole quarter.
- `video_ram_strobe_o` pulses at `cnt` = Q/2-1.
- `video_rom_strobe_o` pulses at `cnt` = Q-1.

DMA window A, quarter 1:
- Arbitration happens at `cnt` = Q-1.

CPU, quarters 2-3:
- `cpu_enable_o` = 1.
- `cpu_read_o` = `cpu_enable_o` & `bus_rw_ni`.
- `cpu_write_o` = `cpu_enable_o` & !`bus_rw_ni` & (`cnt` in 2Q+1..4Q-2).

DMA window B, quarter 3, open only when `cpu_ready_i` sampled at `cnt` = 3Q-1 is 0:
- `cpu_enable_o` = 0 for that quarter.
- Arbitration happens at `cnt` = 3Q-1.

Arbitration:
- Round-robin over `ch_pending_i`.
- Search starts at (last granted + 1) mod `NUM_CH`; the pointer resets to 0.
- No pending channel means the window is idle with all DMA outputs inactive.

Window, at offset o = 0..Q-1 within the quarter:
- `dma_select_o`, `dma_grant_o`, `dma_addr_o`, `dma_data_o` and `dma_rw_no` are latched at arbitration and held for o = 0..Q-1.
- `dma_read_o` (read) or `dma_write_o` (write) = 1 for o = 1..Q-2.
- On a read, `bus_data_i` is captured into `rd_data_o` at o = Q-2.
- `ch_done_o[k]` pulses at o = Q-1.

Channel handshake:
- A channel must drop `ch_pending_i` in the clock after `ch_done_o`. Pending that is still high at the next arbitration point is a new request.
- Channel inputs must be stable from assertion of pending until done. The latched copy makes later changes harmless within the current window.

Outside windows, defaults are `dma_rw_no` = 1 and all other DMA outputs 0.

## Timing
Reset values:
- `cnt` = 0, round-robin pointer = 0.
- `phi2_o` = 0.
- All strobes, selects and `ch_done_o` = 0.
- `dma_rw_no` = 1.
- `rd_data_o` = 0.

Reset behaviour:
- Reset asserted mid-window clears the grant immediately. No `ch_done_o` is issued; the channel re-arbitrates after release.
- After release, the first edge moves `cnt` to 1.

Latency:
- Request-to-done is at most `NUM_CH` CPU cycles with the CPU running, and about half that when halted.
- `ch_done_o` occurs Q-1 clocks after grant.

Simultaneous events:
- With a single channel pending, that channel wins every window, including A and B in the same cycle.
- A `cpu_ready_i` change takes effect only at the next 3Q-1 sample.

## Test plan
1. Reset release, no requests:
   - `phi2_o` is low for `cnt` 0-7 and high for 8-15, period 16.
   - `video_ram_strobe_o` pulses at `cnt` 1 and `video_rom_strobe_o` at `cnt` 3.
   - No DMA outputs active.
2. Channel 0 read of 0x08000 with `bus_data_i` = 0xA5:
   - `dma_addr_o` = 0x08000 for `cnt` 4-7.
   - `dma_read_o` = 1 for `cnt` 5-6.
   - `ch_done_o[0]` pulses at `cnt` 7 and `rd_data_o` = 0xA5.
3. Channel 1 write of 0x3C to 0x1E812:
   - `dma_rw_no` = 0 for `cnt` 4-7.
   - `dma_write_o` = 1 for `cnt` 5-6.
   - `dma_data_o` = 0x3C.
   - `ch_done_o[1]` pulses at `cnt` 7.
4. Both channels pending continuously, CPU running -> grants alternate 0,1,0,1 on successive CPU cycles.
5. `cpu_ready_i` = 0, both channels pending:
   - Grant 0 in `cnt` 4-7, grant 1 in `cnt` 12-15.
   - `cpu_enable_o` = 1 only for `cnt` 8-11.
6. `reset_i` pulsed at `cnt` 5 of a channel 0 read:
   - DMA outputs clear immediately and no `ch_done_o` is issued.
   - After release, channel 0 is granted at the next `cnt` 4 and completes.
